des_round_ctrl: RTL and testbench

Sequencing controller for the 16-round DES Feistel core. Accepts one initial-permuted 64-bit block and a PC-1-permuted 56-bit key, then iterates the rounds. Each round it presents R and the current C/D key state to the external round-function datapath (E expansion, key PC-2 and XOR, S-boxes, P permutation) and folds the returned f-value into L/R. It owns the key-rotation schedule for both encrypt and decrypt, and hands the pre-output block to the final-permutation stage through a valid/ready handshake.

---
 rtl/des_round_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_des_round_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_ctrl.sv
// des_round_ctrl
//   Round sequencer for a 16-round DES Feistel core. It takes one block that
//   has already been through IP and one key that has already been through
//   PC-1. It then runs the rounds against an external combinational
//   round-function datapath (E, PC-2 + XOR, S-boxes, P). The controller owns
//   the L/R registers and the C/D key-rotation schedule for both encrypt and
//   decrypt. It hands the pre-output block R16||L16 downstream through a
//   valid/ready handshake.
//
//   Bit order: vectors carry DES bits MSB-first in [W:1]. Bit 0 is unused on
//   inputs and is driven 0 on outputs. For example, in_block[64] is DES bit 1
//   and in_key_cd[56:29] is C.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready block/key/mode handshake; accepted only in IDLE
//   in_block[64:1]    post-IP block L0||R0
//   in_key_cd[56:1]   post-PC-1 key C0||D0
//   in_decrypt        1 = decrypt key schedule
//   f_r, f_key_cd     current R and C||D to the round function (ROUND only)
//   f_round           current round 1..16, 0 outside ROUND
//   f_result          combinational f(R,K) returned in the same cycle
//   out_valid/ready   pre-output block handshake
//   out_block[64:1]   R16||L16, valid in DONE
//   busy              high in ROUND or DONE
//   abort             only when DES_CTRL_ABORT_EN is defined; drops the
//                     block in flight on the next edge
//
// Build option: define DES_CTRL_ABORT_EN to add the abort input.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new block; in_ready high
// ROUND | one Feistel round per cycle; counter holds round 1..16
// DONE  | out_valid high, result held until out_ready

module des_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DES_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [64:0]      in_block,
  input  logic [56:0]      in_key_cd,
  input  logic             in_decrypt,
  output logic [32:0]      f_r,
  output logic [56:0]      f_key_cd,
  output logic [CNT_W-1:0] f_round,
  input  logic [32:0]      f_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [64:0]      out_block,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS);
  // Decrypt walks the shift table backwards: entering round i+1 uses
  // s(ROUNDS+1-i).
  localparam logic [CNT_W-1:0] REV_BASE = CNT_W'(ROUNDS + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      l_q, l_d;
  logic [31:0]      r_q, r_d;
  logic [55:0]      cd_q, cd_d;
  logic             dec_q, dec_d;

  // DES key-schedule shift amount for round n: 1 for rounds 1, 2, 9, 16.
  function automatic logic [1:0] shift_of(input logic [CNT_W-1:0] n);
    if (n == CNT_W'(1) || n == CNT_W'(2) || n == CNT_W'(9) || n == CNT_W'(16))
      return 2'd1;
    else
      return 2'd2;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  // C and D rotate independently; they never exchange bits.
  function automatic logic [55:0] cd_rotl(input logic [55:0] cd, input logic [1:0] n);
    return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
  endfunction

  function automatic logic [55:0] cd_rotr(input logic [55:0] cd, input logic [1:0] n);
    return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      cd_q    <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      cd_q    <= cd_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    cd_d    = cd_q;
    dec_d   = dec_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          l_d     = in_block[64:33];
          r_d     = in_block[32:1];
          dec_d   = in_decrypt;
          cnt_d   = CNT_W'(1);
          // Encrypt enters round 1 already shifted by s(1). Decrypt starts
          // from C0||D0, because K16 sits at a total rotation of 28.
          cd_d    = in_decrypt ? in_key_cd[56:1] : cd_rotl(in_key_cd[56:1], 2'd1);
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        l_d = r_q;
        r_d = l_q ^ f_result[32:1];
        if (cnt_q == LAST_RND) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          cd_d  = dec_q ? cd_rotr(cd_q, shift_of(REV_BASE - cnt_q))
                        : cd_rotl(cd_q, shift_of(cnt_q + CNT_W'(1)));
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef DES_CTRL_ABORT_EN
    // Abort overrides both the round update and out_ready.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
`endif
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_ROUND) || (state_q == S_DONE);
  assign f_r       = (state_q == S_ROUND) ? {r_q, 1'b0} : '0;
  assign f_key_cd  = (state_q == S_ROUND) ? {cd_q, 1'b0} : '0;
  assign f_round   = (state_q == S_ROUND) ? cnt_q : '0;
  assign out_valid = (state_q == S_DONE);
  // Swap the halves back: the block leaves as R16||L16.
  assign out_block = (state_q == S_DONE) ? {r_q, l_q, 1'b0} : '0;

  logic unused_bits;
  assign unused_bits = ^{in_block[0], in_key_cd[0], f_result[0]};

endmodule

// File: tb/tb_des_round_ctrl.sv
module tb_des_round_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [64:0] in_block;
  logic [56:0] in_key_cd;
  logic        in_decrypt;
  logic [32:0] f_r;
  logic [56:0] f_key_cd;
  logic [4:0]  f_round;
  logic [32:0] f_result;
  logic        out_valid;
  logic        out_ready;
  logic [64:0] out_block;
  logic        busy;
`ifdef DES_CTRL_ABORT_EN
  logic        abort;
`endif

  logic        use_f;
  int          n_pass;
  int          n_tot;

  // Cumulative left shift of C/D after round j = 1..16 (index j-1).
  localparam int CUM[16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

  des_round_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef DES_CTRL_ABORT_EN
    .abort      (abort),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .in_key_cd  (in_key_cd),
    .in_decrypt (in_decrypt),
    .f_r        (f_r),
    .f_key_cd   (f_key_cd),
    .f_round    (f_round),
    .f_result   (f_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in round function: any f works for a Feistel network.
  function automatic logic [31:0] tb_f(input logic [31:0] r, input logic [55:0] k);
    return {r[28:0], r[31:29]} ^ k[55:24] ^ {4'h0, k[27:0]} ^ 32'h5A3C_9617;
  endfunction

  assign f_result = use_f ? {tb_f(f_r[32:1], f_key_cd[56:1]), 1'b0} : 33'h0;

  function automatic logic [27:0] rl28(input logic [27:0] x, input int n);
    logic [27:0] y;
    y = x;
    for (int s = 0; s < n; s++) y = {y[26:0], y[27]};
    return y;
  endfunction

  // Key for round i: encrypt uses K_i, decrypt uses K_(17-i); K_j = rotl by CUM[j-1].
  function automatic logic [55:0] key_at(input logic [55:0] key, input logic dec, input int i);
    int n;
    n = dec ? CUM[16 - i] : CUM[i - 1];
    return {rl28(key[55:28], n), rl28(key[27:0], n)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  128'(in_ready),  128'(1));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_busy"},      128'(busy),      128'(0));
    chk({tag, "_f_round"},   128'(f_round),   128'(0));
    chk({tag, "_f_r"},       128'(f_r),       128'(0));
    chk({tag, "_f_key_cd"},  128'(f_key_cd),  128'(0));
    chk({tag, "_out_block"}, 128'(out_block), 128'(0));
  endtask

  // Runs one block through the controller, checking every round against the model.
  task automatic run_block(input logic [63:0] blk, input logic [55:0] key, input logic dec,
                           input logic usef_i, input int hold, input logic poke,
                           output logic [63:0] res, output logic [55:0] k1);
    logic [31:0] l, r, f;
    logic [55:0] k;
    int edges;
    use_f = usef_i;
    res = '0;
    k1 = '0;
    chk("idle_ready", 128'(in_ready), 128'(1));
    in_block   = {blk, 1'b0};
    in_key_cd  = {key, 1'b0};
    in_decrypt = dec;
    in_valid   = 1'b1;
    out_ready  = (hold == 0);
    step();
    in_valid   = 1'b0;
    // Inputs are sampled only at accept; scramble them afterwards.
    in_block   = ~in_block;
    in_key_cd  = ~in_key_cd;
    in_decrypt = ~dec;
    l = blk[63:32];
    r = blk[31:0];
    edges = 1;
    for (int i = 1; i <= 16; i++) begin
      k = key_at(key, dec, i);
      if (i == 1) k1 = f_key_cd[56:1];
      chk("f_round",     128'(f_round),  128'(i));
      chk("f_key_cd",    128'(f_key_cd), 128'({k, 1'b0}));
      chk("f_r",         128'(f_r),      128'({r, 1'b0}));
      chk("round_flags", 128'({busy, in_ready, out_valid}), 128'(3'b100));
      if (poke) in_valid = i[0];
      f = usef_i ? tb_f(r, k) : 32'h0;
      {l, r} = {r, l ^ f};
      step();
      edges++;
    end
    in_valid = 1'b0;
    chk("latency_edges_17", 128'({edges[4:0], out_valid}), 128'({5'd17, 1'b1}));
    chk("out_block",        128'(out_block), 128'({r, l, 1'b0}));
    res = out_block[64:1];
    for (int h = 0; h < hold; h++) begin
      chk("hold_stable", 128'({out_valid, in_ready, busy, out_block}),
          128'({1'b1, 1'b0, 1'b1, r, l, 1'b0}));
      in_valid = 1'b1;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("back_idle", 128'({in_ready, out_valid, busy}), 128'(3'b100));
  endtask

  typedef struct packed {
    logic [63:0] blk;
    logic [55:0] key;
    logic        dec;
    logic        usef;
    logic        chk_out;
    logic [63:0] exp_out;
    logic [55:0] exp_k1;
  } vec_t;

  vec_t        vecs[5];
  logic [63:0] results[5];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] res;
    logic [55:0] k1;
    n_pass = 0;
    n_tot  = 0;
    use_f      = 1'b0;
    in_valid   = 1'b0;
    in_block   = '0;
    in_key_cd  = '0;
    in_decrypt = 1'b0;
    out_ready  = 1'b1;
`ifdef DES_CTRL_ABORT_EN
    abort      = 1'b0;
`endif
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #5 chk_reset_outputs("reset");
    #14 rst_n = 1'b1;
    step();

    vecs[0] = '{64'h0123456789ABCDEF, 56'h0, 1'b0, 1'b0, 1'b1, 64'h89ABCDEF01234567, 56'h0};
    vecs[1] = '{64'hFEDCBA9876543210, 56'h00000000000001, 1'b1, 1'b0, 1'b1, 64'h76543210FEDCBA98, 56'h00000000000001};
    vecs[2] = '{64'h0123456789ABCDEF, 56'hF0CCAAF556678F, 1'b0, 1'b1, 1'b0, 64'h0, 56'hE19955FAACCF1E};
    vecs[3] = '{64'hA5A5A5A55A5A5A5A, 56'h0123456789ABCD, 1'b1, 1'b1, 1'b0, 64'h0, 56'h0123456789ABCD};
    vecs[4] = '{64'h0, 56'h00000000000001, 1'b0, 1'b0, 1'b1, 64'h0, 56'h00000000000002};

    for (int v = 0; v < 5; v++) begin
      run_block(vecs[v].blk, vecs[v].key, vecs[v].dec, vecs[v].usef, 0, 1'b0, res, k1);
      results[v] = res;
      chk("vec_round1_key", 128'(k1), 128'(vecs[v].exp_k1));
      if (vecs[v].chk_out) chk("vec_out_hand", 128'(res), 128'(vecs[v].exp_out));
    end

    // Decrypting the encrypt result with the same key must restore the block.
    run_block(results[2], 56'hF0CCAAF556678F, 1'b1, 1'b1, 0, 1'b0, res, k1);
    chk("roundtrip_plain", 128'(res), 128'(64'h0123456789ABCDEF));

    // Backpressure for 5 cycles, with in_valid pulses while busy.
    run_block(64'h1122334455667788, 56'h0, 1'b0, 1'b0, 5, 1'b1, res, k1);
    chk("backpressure_out", 128'(res), 128'(64'h5566778811223344));

    // Asynchronous reset at round 8.
    use_f      = 1'b1;
    in_block   = {64'hDEADBEEFCAFEF00D, 1'b0};
    in_key_cd  = {56'hF0CCAAF556678F, 1'b0};
    in_decrypt = 1'b0;
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("pre_reset_round", 128'(f_round), 128'(8));
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    #2 rst_n = 1'b1;
    step();
    run_block(64'h0123456789ABCDEF, 56'hF0CCAAF556678F, 1'b0, 1'b1, 0, 1'b0, res, k1);
    chk("after_reset_result", 128'(res), 128'(results[2]));

`ifdef DES_CTRL_ABORT_EN
    use_f      = 1'b1;
    in_block   = {64'h0123456789ABCDEF, 1'b0};
    in_key_cd  = {56'hF0CCAAF556678F, 1'b0};
    in_decrypt = 1'b0;
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("abort_pre_round", 128'(f_round), 128'(8));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", 128'({in_ready, busy, out_valid, f_round}), 128'({3'b100, 5'd0}));
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
        if (out_valid) seen++;
        step();
      end
      chk("abort_no_valid", 128'(seen), 128'(0));
    end
    run_block(64'h0123456789ABCDEF, 56'hF0CCAAF556678F, 1'b0, 1'b1, 0, 1'b0, res, k1);
    chk("after_abort_result", 128'(res), 128'(results[2]));
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
